// File: rtl/warn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : warn_pkg
//  Description : Shared types and constants for the vehicle warning
//                controller: chime FSM states, default priority-1 mask and
//                symbolic fault channel indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package warn_pkg;

   // Chime pattern controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ON    = 2'd1,
      ST_OFF   = 2'd2,
      ST_SOLID = 2'd3
   } chime_state_t;

   // Default channel count and priority split (channels 5..7 latch and block start)
   localparam int         c_N_CH_DEFAULT    = 8;
   localparam logic [7:0] c_P1_MASK_DEFAULT = 8'b1110_0000;

   // Fault channel indices on the fault_raw / warn buses
   localparam int c_SEATBELT = 0;
   localparam int c_DOOR     = 1;
   localparam int c_HOOD     = 2;
   localparam int c_TRUNK    = 3;
   localparam int c_PASS_SB  = 4;
   localparam int c_BATTERY  = 5;
   localparam int c_AIRBAG   = 6;
   localparam int c_TEMP     = 7;

endpackage : warn_pkg
`default_nettype wire

// File: rtl/warn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : warn_debounce
//  Description : Single-channel fault debouncer. The filtered output flips only
//                after the raw input has disagreed with it for DEB_CYC
//                consecutive cycles; shorter disagreements are discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module warn_debounce
   import warn_pkg::*;
#(
   parameter int DEB_CYC = 4,
   parameter int DEB_W   = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_deb
);

   // Count value on which the filtered output toggles
   localparam logic [DEB_W-1:0] c_LAST = DEB_W'(DEB_CYC - 1);

   logic [DEB_W-1:0] r_cnt;
   logic             r_deb;

   // Disagreement counter and filtered value; agreement restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_deb <= 1'b0;
      end else if (i_raw == r_deb) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_deb <= ~r_deb;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_deb = r_deb;

endmodule : warn_debounce
`default_nettype wire

// File: rtl/vehicle_warn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vehicle_warn_ctrl
//  Description : Debounces N_CH raw fault inputs, latches priority-1 faults
//                until acknowledged, follows priority-2 faults, and drives a
//                timed chime pattern plus a registered ignition start-permit.
//  Revision    : 1.0 - initial release
// ============================================================================
module vehicle_warn_ctrl
   import warn_pkg::*;
#(
   parameter int              N_CH      = c_N_CH_DEFAULT,
   parameter int              DEB_CYC   = 4,
   parameter int              DEB_W     = 4,
   parameter int              CHIME_ON  = 3,
   parameter int              CHIME_OFF = 2,
   parameter logic [N_CH-1:0] P1_MASK   = N_CH'(c_P1_MASK_DEFAULT)
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] i_fault_raw,
   input  logic            i_key,
   input  logic            i_srv,
   input  logic            i_ack,
   output logic [N_CH-1:0] o_warn,
   output logic            o_warn_pri1,
   output logic            o_warn_pri2,
   output logic            o_chime,
   output logic            o_start_permit
);

   // Phase counter must hold the longer of the two pattern half-periods
   localparam int c_PH_MAX = (CHIME_ON > CHIME_OFF) ? CHIME_ON : CHIME_OFF;
   localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

   localparam logic [c_PH_W-1:0] c_ON_LAST  = c_PH_W'(CHIME_ON - 1);
   localparam logic [c_PH_W-1:0] c_OFF_LAST = c_PH_W'(CHIME_OFF - 1);

   logic [N_CH-1:0]   w_deb;
   logic [N_CH-1:0]   r_warn;
   logic              w_pri1;
   logic              w_pri2;
   logic              w_solid_req;
   logic              r_start_permit;

   chime_state_t      r_state;
   chime_state_t      w_state_nxt;
   logic [c_PH_W-1:0] r_phase;
   logic [c_PH_W-1:0] w_phase_nxt;

   // ------------------------------------------------------------------------
   // Per-channel debounce filters
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_deb
      warn_debounce #(
         .DEB_CYC (DEB_CYC),
         .DEB_W   (DEB_W)
      ) u_deb (
         .clk   (clk),
         .rst   (rst),
         .i_raw (i_fault_raw[gi]),
         .o_deb (w_deb[gi])
      );
   end

   // ------------------------------------------------------------------------
   // Warning register: P2 channels follow the filter, P1 channels latch.
   // A P1 bit is cleared only once its filtered fault has gone and ack is
   // high; a still-present fault re-sets it, so set wins over clear.
   // ------------------------------------------------------------------------
   // Warning bits updated from the filtered faults and acknowledge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_warn <= '0;
      end else begin
         r_warn <= (w_deb & ~P1_MASK)
                 | (P1_MASK & (w_deb | (r_warn & {N_CH{~i_ack}})));
      end
   end

   assign w_pri1      = |(r_warn &  P1_MASK);
   assign w_pri2      = |(r_warn & ~P1_MASK);
   assign w_solid_req = w_pri1 & ~i_srv;

   // ------------------------------------------------------------------------
   // Start permit: service mode overrides the P1 start block only
   // ------------------------------------------------------------------------
   // Registered ignition enable
   always_ff @(posedge clk) begin
      if (rst) begin
         r_start_permit <= 1'b0;
      end else begin
         r_start_permit <= i_key & (~w_pri1 | i_srv);
      end
   end

   // ------------------------------------------------------------------------
   // Chime FSM
   // ------------------------------------------------------------------------
   // State and phase counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_phase <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   // Next-state logic; phase restarts from 0 on every state change
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = '0;
      if (!i_key) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_solid_req) begin
                  w_state_nxt = ST_SOLID;
               end else if (w_pri2) begin
                  w_state_nxt = ST_ON;
               end
            end
            ST_ON: begin
               if (w_solid_req) begin
                  w_state_nxt = ST_SOLID;
               end else if (!w_pri2) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_phase == c_ON_LAST) begin
                  w_state_nxt = ST_OFF;
               end else begin
                  w_phase_nxt = r_phase + 1'b1;
               end
            end
            ST_OFF: begin
               if (w_solid_req) begin
                  w_state_nxt = ST_SOLID;
               end else if (!w_pri2) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_phase == c_OFF_LAST) begin
                  w_state_nxt = ST_ON;
               end else begin
                  w_phase_nxt = r_phase + 1'b1;
               end
            end
            ST_SOLID: begin
               if (!w_solid_req) begin
                  w_state_nxt = w_pri2 ? ST_ON : ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (chime is Moore, decoded from the state register)
   // ------------------------------------------------------------------------
   assign o_warn         = r_warn;
   assign o_warn_pri1    = w_pri1;
   assign o_warn_pri2    = w_pri2;
   assign o_chime        = (r_state == ST_ON) | (r_state == ST_SOLID);
   assign o_start_permit = r_start_permit;

endmodule : vehicle_warn_ctrl
`default_nettype wire

// File: tb/tb_vehicle_warn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vehicle_warn_ctrl
//  Description : Directed scoreboard bench for vehicle_warn_ctrl. Each
//                stimulus cycle queues the hand-derived output values expected
//                after that clock edge; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vehicle_warn_ctrl;

   localparam logic [7:0] c_P1 = 8'hE0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] fault_raw = 8'h00;
   logic       key = 1'b0;
   logic       srv = 1'b0;
   logic       ack = 1'b0;
   logic [7:0] warn;
   logic       warn_pri1;
   logic       warn_pri2;
   logic       chime;
   logic       start_permit;

   typedef struct {
      string      nm;
      logic [7:0] warn;
      logic       pri1;
      logic       pri2;
      logic       chime;
      logic       sp;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   vehicle_warn_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .i_fault_raw    (fault_raw),
      .i_key          (key),
      .i_srv          (srv),
      .i_ack          (ack),
      .o_warn         (warn),
      .o_warn_pri1    (warn_pri1),
      .o_warn_pri2    (warn_pri2),
      .o_chime        (chime),
      .o_start_permit (start_permit)
   );

   always #5 clk = ~clk;

   // One compare against a queued expectation
   task automatic check(input string nm, input string fld,
                        input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s actual=%h required=%h @%0t", nm, fld, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge
   task automatic step(input string nm, input logic r, input logic [7:0] raw,
                       input logic k, input logic s, input logic a,
                       input logic [7:0] ew, input logic ech, input logic esp);
      exp_t e;
      @(negedge clk);
      rst = r; fault_raw = raw; key = k; srv = s; ack = a;
      @(posedge clk);
      #1;
      e.nm    = nm;
      e.warn  = ew;
      e.pri1  = |(ew & c_P1);
      e.pri2  = |(ew & ~c_P1);
      e.chime = ech;
      e.sp    = esp;
      q.push_back(e);
   endtask

   // Monitor: compare outputs at the falling edge whenever an expectation waits
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e.nm, "warn",  warn,                e.warn);
            check(e.nm, "pri1",  {7'b0, warn_pri1},   {7'b0, e.pri1});
            check(e.nm, "pri2",  {7'b0, warn_pri2},   {7'b0, e.pri2});
            check(e.nm, "chime", {7'b0, chime},       {7'b0, e.chime});
            check(e.nm, "sp",    {7'b0, start_permit}, {7'b0, e.sp});
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Stimulus
   initial begin
      // 1. Reset, then key with no faults
      step("s1_rst", 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      step("s1_rst", 1, 8'h00, 1, 0, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 3; k++) step("s1_key", 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);

      // 2. Glitch rejection, then held P2 fault and chime pattern
      for (int k = 1; k <= 3; k++) step("s2_glitch", 0, 8'h01, 1, 0, 0, 8'h00, 0, 1);
      for (int k = 1; k <= 4; k++) step("s2_gap",    0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
      for (int k = 1; k <= 20; k++)
         step("s2_hold", 0, 8'h01, 1, 0, 0, (k >= 5) ? 8'h01 : 8'h00,
              (k >= 6) && (((k - 6) % 5) < 3), 1);
      for (int k = 21; k <= 26; k++)
         step("s2_drop", 0, 8'h00, 1, 0, 0, (k <= 24) ? 8'h01 : 8'h00,
              (k <= 25) && (((k - 6) % 5) < 3), 1);

      // 3. P1 latch, early ack ignored, ack after filter clears
      for (int k = 1; k <= 7; k++)
         step("s3_set", 0, 8'h40, 1, 0, 0, (k >= 5) ? 8'h40 : 8'h00, k >= 6, k < 6);
      for (int k = 1; k <= 4; k++) step("s3_ack_early", 0, 8'h00, 1, 0, 1, 8'h40, 1, 0);
      for (int k = 1; k <= 2; k++) step("s3_hold",      0, 8'h00, 1, 0, 0, 8'h40, 1, 0);
      step("s3_ack",   0, 8'h00, 1, 0, 1, 8'h00, 1, 0);
      step("s3_clear", 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);

      // 4. Service mode with P1 and P2 faults: pattern instead of solid
      for (int k = 1; k <= 16; k++)
         step("s4_srv", 0, 8'h84, 1, 1, 0, (k >= 5) ? 8'h84 : 8'h00,
              (k >= 6) && (((k - 6) % 5) < 3), 1);
      step("s4_solid", 0, 8'h84, 1, 0, 0, 8'h84, 1, 0);

      // 5. Key removal during SOLID, then reset during ON
      step("s5_keyoff", 0, 8'h84, 0, 0, 0, 8'h84, 0, 0);
      step("s5_rst1",   1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 7; k++)
         step("s5_on", 0, 8'h01, 1, 0, 0, (k >= 5) ? 8'h01 : 8'h00, k >= 6, 1);
      step("s5_rst_on", 1, 8'h01, 1, 0, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 6; k++)
         step("s5_rerun", 0, 8'h01, 1, 0, 0, (k >= 5) ? 8'h01 : 8'h00, k >= 6, 1);
      step("s5_rst2", 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);

      // 6. Set beats acknowledge on channel 5
      for (int k = 1; k <= 6; k++)
         step("s6_set", 0, 8'h20, 1, 0, 0, (k >= 5) ? 8'h20 : 8'h00, k >= 6, k < 6);
      for (int k = 1; k <= 5; k++)
         step("s6_ack", 0, 8'h00, 1, 0, 1, (k <= 4) ? 8'h20 : 8'h00, 1, 0);
      step("s6_rel", 0, 8'h00, 1, 0, 1, 8'h00, 0, 1);
      for (int k = 1; k <= 7; k++)
         step("s6_reset_ack", 0, 8'h20, 1, 0, 1, (k >= 5) ? 8'h20 : 8'h00, k >= 6, k < 6);

      // Drain the scoreboard
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d required=0 pending entries", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_vehicle_warn_ctrl
`default_nettype wire

// File: doc/vehicle_warn_ctrl.md
# vehicle_warn_ctrl

Clocked, parametrised successor to the combinational vehicle warning logic. It debounces `N_CH` raw fault inputs and splits them into priority-1 faults, which latch until acknowledged, and priority-2 faults, which follow the filtered input. It drives a timed chime pattern and a registered start-permit. It sits between the body-sensor inputs and the dashboard/ignition interface.

## Interface

**Parameters**
- `N_CH`, 8: number of fault channels.
- `DEB_CYC`, 4: consecutive cycles a raw input must differ from its filtered value before the filtered value flips. Valid range is 1 to 2^`DEB_W`−1.
- `DEB_W`, 4: debounce counter width.
- `CHIME_ON`, 3: cycles chime is high per pattern period. Must be ≥1.
- `CHIME_OFF`, 2: cycles chime is low per pattern period. Must be ≥1.
- `P1_MASK`, 8'b1110_0000: bit set means the channel is priority-1 (latching, blocks start).

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fault_raw` in `N_CH`: 1 = fault present. Sensor "ok" signals are inverted upstream.
- `key` in 1: key present.
- `srv` in 1: service mode.
- `ack` in 1: level input; clears latched P1 warnings whose fault has gone.
- `warn` out `N_CH`: per-channel warning.
- `warn_pri1` out 1: OR of `warn & P1_MASK`.
- `warn_pri2` out 1: OR of `warn & ~P1_MASK`.
- `chime` out 1: audible chime drive.
- `start_permit` out 1: ignition enable.

## Operation

- **Debounce (per channel).**
  - `deb[i]` is the filtered value, and `cnt[i]` counts cycles of disagreement.
  - If `fault_raw[i] == deb[i]`, `cnt` is set to 0.
  - Otherwise `cnt` increments. On the edge where `cnt == DEB_CYC−1`, `deb` toggles and `cnt` is set to 0.
  - A disagreement shorter than `DEB_CYC` cycles is discarded. With `DEB_CYC=1`, `deb` is `fault_raw` delayed one cycle.
- **Warning register.**
  - P2 channel: `warn[i] <= deb[i]`.
  - P1 channel: set when `deb[i]=1`. Cleared only when `deb[i]=0` and `ack=1` on the same edge. Set has priority over clear.
  - `ack` has no effect on P2 channels or on a channel whose `deb` is still 1.
- **`warn_pri1` and `warn_pri2`** are combinational from `warn`.
- **`start_permit`** is registered: `start_permit <= key & (~warn_pri1 | srv)`.
  - `srv` bypasses the start block only. Warnings are still displayed.
- **Chime FSM** has four states: IDLE, ON, OFF, SOLID. It uses a phase counter of width ceil(log2(max(`CHIME_ON`,`CHIME_OFF`)+1)).
  - **Any state:** if `key=0`, go to IDLE.
  - **IDLE:**
    - `warn_pri1 & ~srv` → SOLID.
    - Else `warn_pri2` → ON, phase counter set to 0.
  - **ON:**
    - `warn_pri1 & ~srv` → SOLID.
    - `~warn_pri2` → IDLE.
    - After `CHIME_ON` cycles in ON → OFF.
  - **OFF:**
    - `warn_pri1 & ~srv` → SOLID.
    - `~warn_pri2` → IDLE.
    - After `CHIME_OFF` cycles in OFF → ON.
  - **SOLID:**
    - Leaves when `~(warn_pri1 & ~srv)`: to ON if `warn_pri2`, else to IDLE.
  - Output is Moore: `chime = (state==ON) | (state==SOLID)`.

## Timing

- **Reset value of every output is 0.** One `rst` edge sets all `cnt`=0, `deb`=0, `warn`=0, FSM=IDLE, phase=0, `chime`=0, `start_permit`=0. `rst` has priority over all other inputs, including mid-pattern and mid-debounce.
- **Raw fault to `warn`.** With `fault_raw` rising before edge 1 and held:
  - `deb` rises at edge `DEB_CYC`.
  - `warn` rises at edge `DEB_CYC+1`.
  - `warn_pri*` rise in the same cycle as `warn`.
- **`warn` to outputs.** `start_permit` falls one edge after `warn_pri1` rises. The FSM leaves IDLE on the same edge, so `chime` goes high one cycle after `warn` rises.
- **Chime period** is exactly `CHIME_ON+CHIME_OFF` cycles while `warn_pri2` and `key` hold.
- **Simultaneous events.**
  - P1 and P2 faults arriving together: SOLID wins.
  - Fault-set and `ack` on the same edge: warning stays set.

## Structure

- **Package `warn_pkg`** holds:
  - chime state enum (IDLE, ON, OFF, SOLID);
  - default `P1_MASK`;
  - channel index constants (SEATBELT=0, DOOR=1, HOOD=2, TRUNK=3, PASS_SB=4, BATTERY=5, AIRBAG=6, TEMP=7).
- **Sub-module `warn_debounce`** implements one channel's `cnt`/`deb`. It is instantiated `N_CH` times in a generate loop.
- **Top level** contains the warning registers, priority reduction, `start_permit` and the chime FSM.

## Test plan

All scenarios use defaults: `N_CH=8`, `DEB_CYC=4`, `CHIME_ON=3`, `CHIME_OFF=2`, `P1_MASK=8'hE0`.

1. **Start with no faults.** `rst` pulse, then `key=1` with `fault_raw=0` → all outputs 0 at reset; `start_permit=1` one edge later; `chime` stays 0.
2. **Glitch rejection and P2 pattern.** `fault_raw[0]` high for 3 cycles → `warn` stays 0. Held for 20 cycles → `warn[0]=1` at edge 5; `chime` runs 1,1,1,0,0,1,1,1,…; `start_permit` stays 1.
3. **P1 latch and acknowledge.** `fault_raw[6]=1` → `warn[6]`, `warn_pri1`, `start_permit=0`, `chime` solid 1. Drop the fault → `warn[6]` stays 1. `ack` pulse after `deb` clears → `warn[6]=0`, `start_permit=1`, `chime=0`.
4. **Service mode.** `srv=1` with `fault_raw[7]=1` and `fault_raw[2]=1` → `start_permit=1`, `warn_pri1=1`, chime follows the P2 3/2 pattern rather than SOLID.
5. **Reset and key removal mid-pattern.** `rst` during ON → next edge all outputs 0. `key=0` during SOLID → `chime=0` and `start_permit=0` next edge.
6. **Set beats acknowledge.** `ack=1` held on the edge where `deb[5]` re-rises → `warn[5]` stays 1.
